// File: rtl/key_expansion_128.sv
// rtl/key_expansion_128.sv - AES-128 key schedule: one round key per clock into an 11-entry store
module key_expansion_128 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] key_in [0:3],
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        keys_valid,
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_key [0:3]
);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         keys_valid_q, keys_valid_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_d [0:10];
    logic [127:0] key_flat;
    logic [127:0] cur_key;
    logic [127:0] nxt_key;
    logic [127:0] rd_word;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] c);
        case (c)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One AES-128 key-schedule round: RotWord/SubWord/Rcon on word 3, then chained XOR
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] c);
        logic [31:0] w0, w1, w2, w3, rw, t, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        rw = {w3[23:0], w3[31:24]};
        t  = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])} ^ {rcon(c), 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign key_flat = {key_in[0], key_in[1], key_in[2], key_in[3]};

    // Select the entry being expanded from and derive its successor
    always_comb begin
        cur_key = 128'h0;
        for (int i = 0; i < 10; i++) begin
            if (cnt_q == 4'(i)) cur_key = rk_q[i];
        end
        nxt_key = next_key(cur_key, cnt_q);
    end

    // FSM state register plus registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
        end
    end

    // Next state and round counter; start during EXPAND is deliberately not looked at
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EXPAND;
                    cnt_d   = 4'd0;
                end
            end
            EXPAND: begin
                if (cnt_q == 4'd9) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Status outputs: done pulses on the rk[10] write, keys_valid cleared by each accepted start
    always_comb begin
        busy_d       = (state_d == EXPAND);
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;
        if (state_q == IDLE && start) begin
            keys_valid_d = 1'b0;
        end else if (state_q == EXPAND && cnt_q == 4'd9) begin
            done_d       = 1'b1;
            keys_valid_d = 1'b1;
        end
    end

    // Round-key store updates: rk[0] on start, rk[cnt+1] while expanding
    always_comb begin
        rk_d = rk_q;
        if (state_q == IDLE && start) begin
            rk_d[0] = key_flat;
        end else if (state_q == EXPAND) begin
            for (int i = 0; i < 10; i++) begin
                if (cnt_q == 4'(i)) rk_d[i + 1] = nxt_key;
            end
        end
    end

    // Round-key store flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) rk_q[i] <= 128'h0;
        end else begin
            for (int i = 0; i < 11; i++) rk_q[i] <= rk_d[i];
        end
    end

    // Combinational read port; indices past 10 read as zero
    always_comb begin
        rd_word = 128'h0;
        for (int i = 0; i < 11; i++) begin
            if (rd_idx == 4'(i)) rd_word = rk_q[i];
        end
    end

    assign rd_key[0]  = rd_word[127:96];
    assign rd_key[1]  = rd_word[95:64];
    assign rd_key[2]  = rd_word[63:32];
    assign rd_key[3]  = rd_word[31:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = keys_valid_q;

endmodule

// File: doc/key_expansion_128.md
KEY_EXPANSION_128 -- requirements
Module: key_expansion_128

Interface
REQ-001 The block SHALL have no parameters; the key size is fixed at AES-128 with 10 rounds and 11 round keys.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high; the block SHALL clear all state immediately when it asserts.
REQ-004 key_in  input  4x32 (unpacked [0:3])  cipher key words w0..w3; word 0 is the most significant key word.
REQ-005 start  input  1  single-cycle request to expand key_in.
REQ-006 busy  output  1  high while expansion is in progress.
REQ-007 done  output  1  single-cycle pulse when all 11 round keys are stored.
REQ-008 keys_valid  output  1  high while the stored round keys form a complete schedule for the last accepted key.
REQ-009 rd_idx  input  4  round-key index to read, 0..10.
REQ-010 rd_key  output  4x32 (unpacked [0:3])  round key selected by rd_idx.

Function
REQ-011 Storage SHALL be rk[0..10], each entry 4x32 bits, held in flops.
REQ-012 The FSM SHALL have exactly two states, IDLE and EXPAND, plus a 4-bit round counter cnt.
REQ-013 In IDLE with start=1 at edge E0: rk[0]<=key_in; cnt<=0; keys_valid<=0; state<=EXPAND.
REQ-014 In EXPAND at each edge: rk[cnt+1]<=next_key(rk[cnt], cnt); cnt<=cnt+1.
REQ-015 next_key SHALL be the team's combinational one-round AES-128 next-key stage, with these properties:
- RotWord then SubWord applied to word 3;
- XOR with rcon[cnt], where rcon[0]=0x01000000 .. rcon[9]=0x36000000;
- chained XOR of words 0..3.
REQ-016 When cnt==9 in EXPAND, on the edge that writes rk[10] (E10):
- state<=IDLE, cnt<=0;
- done<=1 for exactly one cycle;
- keys_valid<=1.
REQ-017 Latency: start sampled at E0 SHALL give done and keys_valid high in the cycle following E10, i.e. 10 cycles after the start edge.
REQ-018 busy SHALL be registered: high from after E0 through E10; low otherwise.
REQ-019 start while busy=1 SHALL be ignored with no side effects; key_in SHALL only be sampled at E0.
REQ-020 start in the same cycle that done=1 SHALL be accepted as a new E0 and behave as follows:
- done drops after one cycle;
- keys_valid returns to 0 at that edge.
REQ-021 rd_key SHALL be a combinational read of rk[rd_idx]; rd_idx 11..15 SHALL return all zeros.
REQ-022 rd_key for an index not yet written in the current expansion SHALL return whatever that entry currently holds; consumers SHALL gate reads on keys_valid.
REQ-023 All arithmetic is XOR and byte substitution; cnt SHALL never exceed 10 and SHALL never wrap.

Reset
REQ-024 On rst=1, regardless of state, including mid-EXPAND:
- state=IDLE, cnt=0;
- busy=0, done=0, keys_valid=0;
- all rk entries=0, so rd_key=0 for every index.
REQ-025 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-026 FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, start pulse -> the following:
- done exactly 10 cycles after the start edge;
- rk[1]=a0fafe17 88542cb1 23a33939 2a6c7605;
- rk[10]=d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
REQ-027 All-zero key -> the following:
- rk[1]=62636363 62636363 62636363 62636363;
- rk[10]=b4ef5bcb 3e92e211 23e951cf 6f8f188e.
REQ-028 Start pulses with different key_in at cycles 3 and 7 after the first start -> both ignored; the result equals that of the first key; done pulses once.
REQ-029 rst asserted at cnt=5 -> the following:
- busy, done and keys_valid are 0 immediately;
- rd_key=0 for all indices;
- a fresh start afterwards yields the correct FIPS-197 schedule.
REQ-030 Back-to-back: start asserted in the done cycle with the zero key -> keys_valid drops, then the zero-key schedule completes 10 cycles later.
REQ-031 rd_idx=11 and rd_idx=15 -> rd_key all zeros in every state.
